dm_spi_bcast_engine: RTL and testbench

- Parametrised successor to the fixed six-channel deformable-mirror SPI fan-out.
- N_CHAN SPI masters share one timing engine, so every channel shifts one frame at the same time to the same chip-select index. All actuator DACs therefore update together.
- The MSS drives it through an APB slave port. Per-channel TX staging is double-buffered, MISO readback is captured per channel, and a completed-frame counter is provided.
- Sits between the MSS FIC APB slave and the board SPI pins.

---
 rtl/dm_spi_bcast_engine.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_dm_spi_bcast_engine.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_spi_bcast_engine.sv
// dm_spi_bcast_engine
//   N_CHAN SPI masters driven by one shared timing engine, so every channel shifts
//   a FRAME_BITS frame simultaneously to the same chip-select index (mode 0, MSB first).
//   The MSS programs the block over APB; TX staging is double-buffered, the last MISO
//   frame per channel is kept, and completed frames are counted.
//
//   Optional build macro: PPS_TRIGGER_EN adds a pps input that, once armed through
//   CTRL[2], launches a frame on its next rising edge.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   paddr..pwdata         APB slave request (byte address)
//   prdata, pready        APB response, pready a registered single-cycle pulse
//   sck, mosi, miso       per-channel SPI clock / data (all sck identical)
//   ncs                   active-low chip selects, channel c owns [c*NCS +: NCS]
//   pps                   (PPS_TRIGGER_EN only) external pulse-per-second
//   busy                  frame in progress
module dm_spi_bcast_engine #(
  parameter int unsigned N_CHAN     = 6,
  parameter int unsigned NCS        = 4,
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned CLKDIV     = 4,
  parameter int unsigned ADDR_W     = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic [N_CHAN-1:0]     sck,
  output logic [N_CHAN-1:0]     mosi,
  input  logic [N_CHAN-1:0]     miso,
  output logic [N_CHAN*NCS-1:0] ncs,
`ifdef PPS_TRIGGER_EN
  input  logic                  pps,
`endif
  output logic                  busy
);

  localparam int unsigned DW = $clog2(CLKDIV);
  localparam int unsigned BW = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {StIdle, StLoad, StLow, StHigh, StHold, StDone} state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [2:0]            cs_act_q, cs_act_d;
  logic [2:0]            cs_sel_q, cs_sel_d;
  logic                  ovr_q, ovr_d;
  logic [31:0]           fcnt_q, fcnt_d;
  logic                  pready_q, pready_d;
  logic [31:0]           prdata_q, prdata_d;
  logic [FRAME_BITS-1:0] tx_q [N_CHAN];
  logic [FRAME_BITS-1:0] tx_d [N_CHAN];
  logic [FRAME_BITS-1:0] sh_q [N_CHAN];
  logic [FRAME_BITS-1:0] sh_d [N_CHAN];
  logic [FRAME_BITS-1:0] rxs_q [N_CHAN];
  logic [FRAME_BITS-1:0] rxs_d [N_CHAN];
  logic [FRAME_BITS-1:0] rx_q [N_CHAN];
  logic [FRAME_BITS-1:0] rx_d [N_CHAN];

  // ---------------------------------------------------------------- APB decode
  logic       acc, wr_commit, aligned;
  logic       sel_ctrl, sel_fcnt, sel_tx, sel_rx;
  logic [3:0] chan_idx;
  logic [31:0] rd_val;

  assign acc       = psel & penable;
  // Writes land in the cycle pready is high, while the master still holds the request.
  assign wr_commit = acc & pwrite & pready_q;
  assign aligned   = (paddr[1:0] == 2'b00);
  assign chan_idx  = paddr[5:2];
  assign sel_ctrl  = aligned && (paddr[ADDR_W-1:2] == '0);
  assign sel_fcnt  = aligned && (paddr[ADDR_W-1:2] == (ADDR_W-2)'(1));
  assign sel_tx    = aligned && (paddr[ADDR_W-1:6] == (ADDR_W-6)'(1)) &&
                     ({1'b0, chan_idx} < 5'(N_CHAN));
  assign sel_rx    = aligned && (paddr[ADDR_W-1:6] == (ADDR_W-6)'(2)) &&
                     ({1'b0, chan_idx} < 5'(N_CHAN));

  logic frame_busy, wr_ctrl, go_req, go_ok, go_bad, cs_new_ok;
  assign frame_busy = (state_q != StIdle);
  assign wr_ctrl    = wr_commit & sel_ctrl;
  assign go_req     = wr_ctrl & pwdata[0];
  assign cs_new_ok  = ({1'b0, pwdata[10:8]} < 4'(NCS));
  assign go_ok      = go_req & ~frame_busy & cs_new_ok;
  assign go_bad     = go_req & ~go_ok;

  logic unused_pwdata;
  assign unused_pwdata = ^pwdata;

  // ---------------------------------------------------------------- PPS trigger
  logic armed, pps_start, pps_ovr;
`ifdef PPS_TRIGGER_EN
  logic [2:0] pps_sync_q;
  logic       pps_edge_q, pps_go_q, pps_go_d, armed_q, armed_d, cs_cur_ok;

  assign cs_cur_ok = ({1'b0, cs_sel_q} < 4'(NCS));
  assign armed     = armed_q;
  // A same-cycle software GO takes precedence over the pps launch.
  assign pps_start = pps_go_q & ~frame_busy & ~go_ok & cs_cur_ok;

  always_comb begin
    pps_go_d = 1'b0;
    pps_ovr  = 1'b0;
    armed_d  = armed_q;
    if (pps_edge_q && armed_q) begin
      if (frame_busy || !cs_cur_ok) pps_ovr = 1'b1;
      else                          pps_go_d = 1'b1;
    end
    if (pps_go_q && !pps_start) pps_ovr = 1'b1;
    if (pps_start) armed_d = 1'b0;
    if (wr_ctrl && pwdata[2]) armed_d = 1'b1;
  end

  // Two sync flops, one history flop, then the registered edge and launch pulse:
  // ncs drops 4 cycles after pps is first sampled high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pps_sync_q <= '0;
      pps_edge_q <= 1'b0;
      pps_go_q   <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      pps_sync_q <= {pps_sync_q[1:0], pps};
      pps_edge_q <= pps_sync_q[1] & ~pps_sync_q[2];
      pps_go_q   <= pps_go_d;
      armed_q    <= armed_d;
    end
  end
`else
  assign armed     = 1'b0;
  assign pps_start = 1'b0;
  assign pps_ovr   = 1'b0;
`endif

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    cs_act_d = cs_act_q;
    cs_sel_d = cs_sel_q;
    ovr_d    = ovr_q;
    fcnt_d   = fcnt_q;
    tx_d     = tx_q;
    sh_d     = sh_q;
    rxs_d    = rxs_q;
    rx_d     = rx_q;

    if (wr_ctrl) cs_sel_d = pwdata[10:8];
    // Clear is applied before a rejected GO can set the flag again.
    if (wr_ctrl && pwdata[1]) ovr_d = 1'b0;
    if (go_bad || pps_ovr) ovr_d = 1'b1;

    for (int c = 0; c < N_CHAN; c++) begin
      if (wr_commit && sel_tx && (chan_idx == 4'(c))) tx_d[c] = pwdata[FRAME_BITS-1:0];
    end

    unique case (state_q)
      StIdle: begin
        if (go_ok) begin
          state_d  = StLoad;
          cs_act_d = pwdata[10:8];
        end else if (pps_start) begin
          state_d  = StLoad;
          cs_act_d = cs_sel_q;
        end
      end
      StLoad: begin
        state_d = StLow;
        div_d   = '0;
        bit_d   = '0;
        sh_d    = tx_q;
      end
      StLow: begin
        if (div_q == DW'(CLKDIV - 1)) begin
          div_d   = '0;
          state_d = StHigh;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StHigh: begin
        if (div_q == '0) begin
          for (int c = 0; c < N_CHAN; c++) begin
            rxs_d[c] = {rxs_q[c][FRAME_BITS-2:0], miso[c]};
          end
        end
        if (div_q == DW'(CLKDIV - 1)) begin
          div_d = '0;
          for (int c = 0; c < N_CHAN; c++) sh_d[c] = sh_q[c] << 1;
          if (bit_q == BW'(FRAME_BITS - 1)) begin
            state_d = StHold;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = StLow;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StHold: begin
        if (div_q == DW'(CLKDIV - 1)) begin
          div_d   = '0;
          state_d = StDone;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        rx_d    = rxs_q;
        fcnt_d  = fcnt_q + 32'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------- read mux
  always_comb begin
    rd_val = '0;
    if (sel_ctrl) begin
      rd_val[0]    = frame_busy;
      rd_val[1]    = ovr_q;
      rd_val[2]    = armed;
      rd_val[10:8] = cs_sel_q;
    end
    if (sel_fcnt) rd_val = fcnt_q;
    for (int c = 0; c < N_CHAN; c++) begin
      if (sel_tx && (chan_idx == 4'(c))) rd_val[FRAME_BITS-1:0] = tx_q[c];
      if (sel_rx && (chan_idx == 4'(c))) rd_val[FRAME_BITS-1:0] = rx_q[c];
    end
  end

  assign pready_d = acc & ~pready_q;
  assign prdata_d = (acc && !pready_q && !pwrite) ? rd_val : '0;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      cs_act_q <= '0;
      cs_sel_q <= '0;
      ovr_q    <= 1'b0;
      fcnt_q   <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      for (int c = 0; c < N_CHAN; c++) begin
        tx_q[c]  <= '0;
        sh_q[c]  <= '0;
        rxs_q[c] <= '0;
        rx_q[c]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      cs_act_q <= cs_act_d;
      cs_sel_q <= cs_sel_d;
      ovr_q    <= ovr_d;
      fcnt_q   <= fcnt_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      tx_q     <= tx_d;
      sh_q     <= sh_d;
      rxs_q    <= rxs_d;
      rx_q     <= rx_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    sck  = {N_CHAN{state_q == StHigh}};
    mosi = '0;
    ncs  = '1;
    for (int c = 0; c < N_CHAN; c++) begin
      if (state_q == StLoad)                          mosi[c] = tx_q[c][FRAME_BITS-1];
      else if (state_q == StLow || state_q == StHigh) mosi[c] = sh_q[c][FRAME_BITS-1];
    end
    if (state_q inside {StLoad, StLow, StHigh, StHold}) begin
      for (int c = 0; c < N_CHAN; c++) begin
        for (int k = 0; k < NCS; k++) begin
          if (cs_act_q == 3'(k)) ncs[c*NCS + k] = 1'b0;
        end
      end
    end
  end

  assign busy   = frame_busy;
  assign pready = pready_q;
  assign prdata = prdata_q;

endmodule

// File: tb/tb_dm_spi_bcast_engine.sv
module tb_dm_spi_bcast_engine;
  localparam int N_CHAN   = 6;
  localparam int NCS      = 4;
  localparam int FB       = 24;
  localparam int CLKDIV   = 4;
  localparam int ADDR_W   = 14;
  localparam int BUSY_CYC = 2 + 2 * CLKDIV * FB + CLKDIV;
  localparam logic [ADDR_W-1:0] A_CTRL = 14'h000;
  localparam logic [ADDR_W-1:0] A_FCNT = 14'h004;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ADDR_W-1:0]     paddr;
  logic                  psel, penable, pwrite;
  logic [31:0]           pwdata, prdata;
  logic                  pready;
  logic [N_CHAN-1:0]     sck, mosi;
  logic [N_CHAN-1:0]     miso = '0;
  logic [N_CHAN*NCS-1:0] ncs;
  logic                  busy;
  logic                  pps;

  dm_spi_bcast_engine #(
    .N_CHAN(N_CHAN), .NCS(NCS), .FRAME_BITS(FB), .CLKDIV(CLKDIV), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .sck(sck), .mosi(mosi), .miso(miso), .ncs(ncs),
`ifdef PPS_TRIGGER_EN
    .pps(pps),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the registers should hold and what each frame should show.
  logic [FB-1:0] tx_stage [N_CHAN];
  logic [FB-1:0] tx_frame [N_CHAN];
  logic [FB-1:0] rx_model [N_CHAN];
  logic [FB-1:0] miso_word [N_CHAN];
  int            fcnt_model;
  logic [N_CHAN*NCS-1:0] exp_ncs = '1;
  int            exp_low_cyc;

  // Frame monitor and SPI slave model, sampled on the falling clock edge.
  logic prev_busy = 1'b0, prev_sck = 1'b0;
  int   busy_cnt, edge_cnt, low_cnt, bad_ncs_cnt, skew_cnt, miso_idx, first_low_cyc;
  logic [FB-1:0] mosi_cap [N_CHAN];

  always @(negedge clk) begin
    if (busy === 1'b1 && !prev_busy) begin
      busy_cnt = 0; edge_cnt = 0; low_cnt = 0; bad_ncs_cnt = 0; skew_cnt = 0;
      miso_idx = 0; first_low_cyc = -1;
      for (int c = 0; c < N_CHAN; c++) begin
        mosi_cap[c] = '0;
        miso[c] = miso_word[c][FB-1];
      end
    end
    if (busy === 1'b1) begin
      busy_cnt++;
      if (ncs == exp_ncs) begin
        low_cnt++;
        if (first_low_cyc < 0) first_low_cyc = cyc;
      end else if (ncs != '1) begin
        bad_ncs_cnt++;
      end
      if (sck != '0 && sck != '1) skew_cnt++;
      if (sck[0] && !prev_sck) begin
        edge_cnt++;
        for (int c = 0; c < N_CHAN; c++) mosi_cap[c] = {mosi_cap[c][FB-2:0], mosi[c]};
      end
      if (!sck[0] && prev_sck) begin
        miso_idx++;
        if (miso_idx < FB)
          for (int c = 0; c < N_CHAN; c++) miso[c] = miso_word[c][FB-1-miso_idx];
      end
    end
    prev_busy = (busy === 1'b1);
    prev_sck  = (sck[0] === 1'b1);
  end

  int commit_cyc;

  task automatic apb(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                     output logic [31:0] q);
    int n;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    n = 0;
    while (!pready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!pready) check_eq("pready_timeout", 32'(pready), 32'd1);
    q = prdata;
    commit_cyc = cyc;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check_eq("pready_pulse", {31'd0, pready}, 32'd0);
  endtask

  task automatic apb_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    logic [31:0] q;
    apb(1'b1, a, d, q);
  endtask

  task automatic apb_rd(input logic [ADDR_W-1:0] a, output logic [31:0] q);
    apb(1'b0, a, 32'd0, q);
  endtask

  function automatic logic [ADDR_W-1:0] tx_addr(input int c);
    return ADDR_W'(32'h40 + 4 * c);
  endfunction

  function automatic logic [ADDR_W-1:0] rx_addr(input int c);
    return ADDR_W'(32'h80 + 4 * c);
  endfunction

  task automatic write_tx(input int c, input logic [31:0] v);
    apb_wr(tx_addr(c), v);
    tx_stage[c] = v[FB-1:0];
  endtask

  task automatic set_frame(input logic [2:0] cs);
    for (int c = 0; c < N_CHAN; c++) tx_frame[c] = tx_stage[c];
    exp_ncs = '1;
    for (int c = 0; c < N_CHAN; c++) exp_ncs[c*NCS + int'(cs)] = 1'b0;
  endtask

  task automatic go_frame(input logic [2:0] cs, input logic clr);
    set_frame(cs);
    apb_wr(A_CTRL, {21'd0, cs, 6'd0, clr, 1'b1});
    exp_low_cyc = commit_cyc + 1;
  endtask

  task automatic wait_busy_cnt(input int target);
    int n = 0;
    while (busy_cnt < target && n < 4 * BUSY_CYC) begin
      @(negedge clk);
      n++;
    end
    check_eq("busy_progress", 32'(busy_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4 * BUSY_CYC) begin
      @(negedge clk);
      n++;
    end
    check_eq("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic finish_frame();
    logic [31:0] q;
    wait_idle();
    fcnt_model++;
    for (int c = 0; c < N_CHAN; c++) rx_model[c] = miso_word[c];
    check_eq("busy_cycles", 32'(busy_cnt), 32'(BUSY_CYC));
    check_eq("sck_edges", 32'(edge_cnt), 32'(FB));
    check_eq("ncs_low_cycles", 32'(low_cnt), 32'(BUSY_CYC - 1));
    check_eq("ncs_wrong_cs", 32'(bad_ncs_cnt), 32'd0);
    check_eq("sck_skew", 32'(skew_cnt), 32'd0);
    check_eq("ncs_latency", 32'(first_low_cyc), 32'(exp_low_cyc));
    for (int c = 0; c < N_CHAN; c++) check_eq("mosi_frame", {8'd0, mosi_cap[c]}, {8'd0, tx_frame[c]});
    apb_rd(A_FCNT, q);
    check_eq("fcnt", q, 32'(fcnt_model));
    for (int c = 0; c < N_CHAN; c++) begin
      apb_rd(rx_addr(c), q);
      check_eq("rxdata", q, {8'd0, rx_model[c]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    logic [2:0]  cs;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pps = 1'b0;
    fcnt_model = 0;
    for (int c = 0; c < N_CHAN; c++) begin
      tx_stage[c] = '0; rx_model[c] = '0; miso_word[c] = '0; tx_frame[c] = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_ncs", {8'd0, ncs}, {8'd0, {N_CHAN*NCS{1'b1}}});
    check_eq("rst_sck", {26'd0, sck}, 32'd0);
    check_eq("rst_mosi", {26'd0, mosi}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_pready", {31'd0, pready}, 32'd0);
    check_eq("rst_prdata", prdata, 32'd0);
    rst = 1'b0;

    apb_rd(A_CTRL, q); check_eq("rst_ctrl", q, 32'd0);
    apb_rd(A_FCNT, q); check_eq("rst_fcnt", q, 32'd0);
    for (int c = 0; c < N_CHAN; c++) begin
      apb_rd(tx_addr(c), q); check_eq("rst_tx", q, 32'd0);
      apb_rd(rx_addr(c), q); check_eq("rst_rx", q, 32'd0);
    end

    // Directed frame: cs 2, known TX and MISO patterns, GO while busy.
    for (int c = 0; c < N_CHAN; c++) begin
      write_tx(c, 32'hA5A5A5 + 32'(c));
      miso_word[c] = 24'h123456 + 24'(c);
    end
    apb_rd(tx_addr(5), q); check_eq("tx_readback", q, 32'hA5A5AA);
    go_frame(3'd2, 1'b0);
    wait_busy_cnt(50);
    apb_wr(A_CTRL, 32'h201);
    apb_rd(rx_addr(0), q); check_eq("rx_midframe", q, {8'd0, rx_model[0]});
    apb_rd(A_CTRL, q); check_eq("ovr_busy", q, 32'h203);
    for (int c = 0; c < N_CHAN; c++) write_tx(c, $urandom);
    finish_frame();

    apb_rd(A_CTRL, q); check_eq("ovr_sticky", q, 32'h202);
    apb_wr(A_CTRL, 32'h2);
    apb_rd(A_CTRL, q); check_eq("ovr_clear", q, 32'h000);
    apb_wr(A_CTRL, 32'h701);
    begin
      int busy_seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (busy) busy_seen++;
      end
      check_eq("bad_cs_no_frame", 32'(busy_seen), 32'd0);
    end
    apb_rd(A_CTRL, q); check_eq("bad_cs_ovr", q, 32'h702);
    apb_rd(A_FCNT, q); check_eq("bad_cs_fcnt", q, 32'(fcnt_model));
    apb_wr(A_CTRL, 32'h703);
    apb_rd(A_CTRL, q); check_eq("clr_go_rejected", q, 32'h702);

    // Clear together with an accepted GO: frame starts and overrun ends clear.
    for (int c = 0; c < N_CHAN; c++) miso_word[c] = 24'($urandom);
    go_frame(3'd0, 1'b1);
    apb_rd(A_CTRL, q); check_eq("clr_go_ok", q, 32'h001);
    finish_frame();

    // Randomised frames with staging rewritten mid-frame.
    for (int f = 0; f < 4; f++) begin
      cs = 3'($urandom_range(0, NCS - 1));
      for (int c = 0; c < N_CHAN; c++) miso_word[c] = 24'($urandom);
      go_frame(cs, 1'b0);
      wait_busy_cnt(int'($urandom_range(5, BUSY_CYC - 40)));
      begin
        int k = int'($urandom_range(0, N_CHAN - 1));
        write_tx(k, $urandom);
        apb_rd(tx_addr(k), q); check_eq("tx_stage_rb", q, {8'd0, tx_stage[k]});
      end
      finish_frame();
    end

    // Reset in the middle of a frame.
    for (int c = 0; c < N_CHAN; c++) miso_word[c] = 24'($urandom);
    go_frame(3'd3, 1'b0);
    wait_busy_cnt(100);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ncs", {8'd0, ncs}, {8'd0, {N_CHAN*NCS{1'b1}}});
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_sck", {26'd0, sck}, 32'd0);
    check_eq("mid_rst_mosi", {26'd0, mosi}, 32'd0);
    rst = 1'b0;
    fcnt_model = 0;
    for (int c = 0; c < N_CHAN; c++) begin
      rx_model[c] = '0; tx_stage[c] = '0;
    end
    apb_rd(A_FCNT, q); check_eq("mid_rst_fcnt", q, 32'd0);
    apb_rd(rx_addr(0), q); check_eq("mid_rst_rx", q, 32'd0);
    for (int c = 0; c < N_CHAN; c++) write_tx(c, $urandom);
    go_frame(3'd1, 1'b0);
    finish_frame();

`ifdef PPS_TRIGGER_EN
    apb_wr(A_CTRL, 32'h104);
    apb_rd(A_CTRL, q); check_eq("pps_armed", q, 32'h104);
    for (int c = 0; c < N_CHAN; c++) miso_word[c] = 24'($urandom);
    set_frame(3'd1);
    @(negedge clk);
    pps = 1'b1;
    @(negedge clk);
    exp_low_cyc = cyc + 4;
    begin
      int n = 0;
      while (!busy && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_eq("pps_start", {31'd0, busy}, 32'd1);
    end
    pps = 1'b0;
    apb_rd(A_CTRL, q); check_eq("pps_disarm", q, 32'h101);
    finish_frame();

    apb_wr(A_CTRL, 32'h104);
    go_frame(3'd1, 1'b0);
    apb_rd(A_CTRL, q); check_eq("sw_go_keeps_arm", q, 32'h105);
    pps = 1'b1;
    repeat (8) @(negedge clk);
    pps = 1'b0;
    apb_rd(A_CTRL, q); check_eq("pps_busy_ovr", q, 32'h107);
    finish_frame();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
